// File: rtl/ram_run_controller_pkg.sv
// Shared definitions for the RAM run controller: run-state encoding,
// fb_cpu opcode values (used by the external halt decoder) and default widths.
package ram_run_controller_pkg;

  localparam int unsigned DEF_ADDRESS_WIDTH = 6;
  localparam int unsigned DEF_DATA_WIDTH    = 10;
  localparam int unsigned OPCODE_WIDTH      = 4;

  // Two-bit run state; the fourth code is unused and recovers to ST_LOAD.
  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } run_state_t;

  // fb_cpu instruction opcodes (upper OPCODE_WIDTH bits of a RAM word).
  typedef enum logic [OPCODE_WIDTH-1:0] {
    OP_LOD = 4'd0,
    OP_STO = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_MUL = 4'd4,
    OP_DIV = 4'd5,
    OP_JMP = 4'd6,
    OP_JMZ = 4'd7,
    OP_NOP = 4'd8,
    OP_HLT = 4'd9
  } opcode_t;

  // The host may touch the RAM whenever the CPU is not running.
  function automatic logic host_owns_ram(run_state_t s);
    return (s == ST_LOAD) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/ram_run_controller_if.sv
// Host (loader/debug) access port of the RAM run controller.
// The host holds req/we/addr/wdata stable until gnt; read data returns
// one cycle after a granted read, qualified by rvalid.
interface ram_run_controller_if
  import ram_run_controller_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH
) ();

  logic                     host_req;
  logic                     host_we;
  logic [ADDRESS_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0]    host_wdata;
  logic                     host_gnt;
  logic                     host_rvalid;
  logic [DATA_WIDTH-1:0]    host_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata
  );

endinterface

// File: rtl/ram_run_controller_run_watchdog.sv
// Run-cycle watchdog: saturating cycle counter, expiry compare and the
// sticky timeout flag describing how the last run ended.
module run_watchdog
  import ram_run_controller_pkg::*;
#(
  parameter int unsigned CYC_W      = 16,
  parameter int unsigned MAX_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             restart,
  input  logic             running,
  input  logic             halt,
  output logic             expire,
  output logic             timeout,
  output logic [CYC_W-1:0] cycles
);

  localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(MAX_CYCLES - 1);

  // Watchdog hit: the current run clock is the last one allowed.
  assign expire = running && (cycles == CYC_LAST);

  // The edge that ends a run does not count, so a watchdog-terminated run
  // leaves cycles at MAX_CYCLES-1; halt takes priority over the watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles  <= '0;
      timeout <= 1'b0;
    end else if (restart) begin
      cycles  <= '0;
      timeout <= 1'b0;
    end else if (running) begin
      if (halt) begin
        timeout <= 1'b0;
      end else if (expire) begin
        timeout <= 1'b1;
      end else if (cycles != CYC_LIMIT) begin
        cycles <= cycles + CYC_W'(1);
      end
    end
  end

endmodule

// File: rtl/ram_run_controller.sv
// RAM run controller: owns the single-port program/data RAM, lets the host
// load and inspect it while fb_cpu is held in reset, and hands it to the CPU
// for one run that ends on halt or on the cycle watchdog.
module ram_run_controller
  import ram_run_controller_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = DEF_ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int unsigned CYC_W         = 16,
  parameter int unsigned MAX_CYCLES    = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     clear,
  ram_run_controller_if.slave      host,
  output logic                     cpu_rst,
  input  logic                     cpu_halt,
  input  logic [ADDRESS_WIDTH-1:0] cpu_mar,
  input  logic                     cpu_wr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata,
  output logic                     busy,
  output logic                     done,
  output logic                     timeout,
  output logic [CYC_W-1:0]         cycles
);

  run_state_t state;
  logic       host_ok;
  logic       host_gnt;
  logic       start_accept;
  logic       running;
  logic       expire;
  logic       rvalid_q;

  assign host_ok      = host_owns_ram(state);
  assign running      = (state == ST_RUN);
  assign start_accept = start && host_ok;

  // Grant is suppressed while reset is asserted even though state reads LOAD.
  assign host_gnt      = rst && host.host_req && host_ok;
  assign host.host_gnt = host_gnt;

  run_watchdog #(
    .CYC_W      (CYC_W),
    .MAX_CYCLES (MAX_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .restart (start_accept),
    .running (running),
    .halt    (cpu_halt),
    .expire  (expire),
    .timeout (timeout),
    .cycles  (cycles)
  );

  // Run sequencer; cpu_rst/busy/done are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_LOAD;
      cpu_rst <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (start) begin
            state   <= ST_RUN;
            cpu_rst <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end
        end
        ST_RUN: begin
          if (cpu_halt || expire) begin
            state   <= ST_DONE;
            cpu_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        ST_DONE: begin
          if (start) begin
            state   <= ST_RUN;
            cpu_rst <= 1'b0;
            busy    <= 1'b1;
            done    <= 1'b0;
          end else if (clear) begin
            state   <= ST_LOAD;
            cpu_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        default: begin
          state   <= ST_LOAD;
          cpu_rst <= 1'b1;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  // RAM port mux: granted host first, then the running CPU, else idle.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (host_gnt) begin
      ram_we    = host.host_we;
      ram_addr  = host.host_addr;
      ram_wdata = host.host_wdata;
    end else if (running) begin
      ram_we    = cpu_wr;
      ram_addr  = cpu_mar;
      ram_wdata = cpu_wdata;
    end
  end

  // Read-valid tracks the one-cycle RAM read latency of a granted host read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= host_gnt && !host.host_we;
    end
  end

  assign host.host_rvalid = rvalid_q;
  assign host.host_rdata  = rvalid_q ? ram_rdata : '0;
  assign cpu_rdata        = ram_rdata;

endmodule

// File: tb/tb_ram_run_controller.sv
// Bench for ram_run_controller: behavioural RAM and a small fb_cpu model,
// randomized programs, and a scoreboard of expected host reads and run results.
module tb_ram_run_controller;

  localparam int AW   = 6;
  localparam int DW   = 10;
  localparam int CW   = 16;
  localparam int MAXC = 64;
  localparam int DMSK = (1 << DW) - 1;

  logic          clk = 1'b0;
  logic          rst, start, clear;
  logic          cpu_rst, cpu_halt, cpu_wr, ram_we, busy, done, timeout;
  logic [AW-1:0] cpu_mar, ram_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata, ram_wdata, ram_rdata;
  logic [CW-1:0] cycles;

  always #5 clk = ~clk;

  ram_run_controller_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) hif ();

  ram_run_controller #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .CYC_W         (CW),
    .MAX_CYCLES    (MAXC)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .clear     (clear),
    .host      (hif),
    .cpu_rst   (cpu_rst),
    .cpu_halt  (cpu_halt),
    .cpu_mar   (cpu_mar),
    .cpu_wr    (cpu_wr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .cycles    (cycles)
  );

  // Single-port RAM with registered read (blram behaviour).
  logic [DW-1:0] mem [64];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Scoreboard state and the expected RAM image.
  typedef struct { int data; int due; } rd_t;
  rd_t exp_rd [$];
  bit  exp_run [$];
  int  ref_mem [64];

  function automatic int enc(input int op, input int arg);
    return op * 64 + arg;
  endfunction

  // fb_cpu model: fetch, operand read, execute; halts by raising cpu_halt.
  int            pc, acc, phase, op, arg, opr;
  logic [DW-1:0] ir;
  initial begin
    cpu_halt = 1'b0; cpu_wr = 1'b0; cpu_mar = '0; cpu_wdata = '0;
    pc = 0; acc = 0; phase = 0; op = 0; arg = 0; opr = 0; ir = '0;
    forever begin
      @(negedge clk);
      if (cpu_rst !== 1'b0) begin
        pc = 0; acc = 0; phase = 0; cpu_halt = 1'b0; cpu_wr = 1'b0; cpu_mar = '0;
      end else begin
        case (phase)
          0: begin cpu_wr = 1'b0; cpu_mar = AW'(pc); phase = 1; end
          1: begin
            ir = cpu_rdata; op = int'(ir[9:6]); arg = int'(ir[5:0]);
            pc = (pc + 1) % 64; phase = 0;
            case (op)
              0, 2, 3, 4, 5: begin cpu_mar = AW'(arg); phase = 2; end
              1: begin cpu_mar = AW'(arg); cpu_wdata = DW'(acc); cpu_wr = 1'b1; end
              6: pc = arg;
              7: if (acc == 0) pc = arg;
              9: begin cpu_halt = 1'b1; phase = 3; end
              default: ;
            endcase
          end
          2: begin
            opr = int'(cpu_rdata);
            case (op)
              0: acc = opr;
              2: acc = (acc + opr) & DMSK;
              3: acc = (acc - opr) & DMSK;
              4: acc = (acc * opr) & DMSK;
              default: acc = (opr == 0) ? 0 : acc / opr;
            endcase
            phase = 0;
          end
          default: ;
        endcase
      end
    end
  end

  // Monitor: host read scoreboard and end-of-run checks.
  int  runclks = 0;
  int  last_runclks = 0;
  bit  prev_busy = 1'b0;
  rd_t mon_e;
  bit  mon_t;
  always begin
    @(negedge clk);
    #2;
    if (!rst) begin
      prev_busy = 1'b0;
      runclks   = 0;
    end else begin
      if (hif.host_rvalid) begin
        if (exp_rd.size() == 0) check("unexpected_rvalid", int'(hif.host_rvalid), 0);
        else begin
          mon_e = exp_rd.pop_front();
          check("host_rdata", int'(hif.host_rdata), mon_e.data);
          check("rvalid_cycle", cyc, mon_e.due);
        end
      end else if (exp_rd.size() > 0 && exp_rd[0].due <= cyc) begin
        mon_e = exp_rd.pop_front();
        check("rvalid_missing", int'(hif.host_rvalid), 1);
      end
      if (busy) begin
        if (!prev_busy) begin
          runclks = 0;
          check("cycles_at_run_start", int'(cycles), 0);
          check("cpu_rst_in_run", int'(cpu_rst), 0);
        end
        runclks++;
      end else if (prev_busy && done) begin
        last_runclks = runclks;
        if (exp_run.size() == 0) check("unexpected_done", int'(done), 0);
        else begin
          mon_t = exp_run.pop_front();
          check("run_timeout", int'(timeout), int'(mon_t));
          check("run_cycles", int'(cycles), runclks - 1);
          check("cpu_rst_in_done", int'(cpu_rst), 1);
        end
      end
      prev_busy = busy;
    end
  end

  bit last_gnt_after_run;
  bit last_gnt_done;

  task automatic host_op(input bit we, input int addr, input int wd);
    bit granted = 1'b0;
    bit was_busy = 1'b0;
    @(negedge clk);
    hif.host_req = 1'b1; hif.host_we = we;
    hif.host_addr = AW'(addr); hif.host_wdata = DW'(wd);
    #1;
    for (int n = 0; n < 400; n++) begin
      if (hif.host_gnt && !busy) begin granted = 1'b1; break; end
      if (busy) check("gnt_during_run", int'(hif.host_gnt), 0);
      was_busy = busy;
      @(negedge clk); #1;
    end
    if (!granted) check("gnt_timeout", int'(hif.host_gnt), 1);
    else begin
      last_gnt_after_run = was_busy;
      last_gnt_done      = done;
      if (we) ref_mem[addr] = wd & DMSK;
      else exp_rd.push_back('{ref_mem[addr], cyc + 1});
    end
    @(negedge clk);
    hif.host_req = 1'b0; hif.host_we = 1'b0;
  endtask

  task automatic host_burst(input int base, input int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      hif.host_req = 1'b1; hif.host_we = 1'b0; hif.host_addr = AW'(base + i);
      #1;
      check("burst_gnt", int'(hif.host_gnt), 1);
      if (hif.host_gnt) exp_rd.push_back('{ref_mem[base + i], cyc + 1});
      @(negedge clk);
    end
    hif.host_req = 1'b0;
  endtask

  task automatic pulse_start(input bit exp_to);
    exp_run.push_back(exp_to);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    #1;
    check("clear_busy", int'(busy), 0);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk); #3;
      if (done) begin seen = 1'b1; break; end
    end
    if (!seen) check("done_timeout", int'(done), 1);
  endtask

  task automatic load_prog(input int op2, input int a, input int b);
    host_op(1'b1, 0, enc(0, 50));
    host_op(1'b1, 1, enc(op2, 51));
    host_op(1'b1, 2, enc(1, 52));
    host_op(1'b1, 3, enc(9, 0));
    host_op(1'b1, 50, a);
    host_op(1'b1, 51, b);
  endtask

  function automatic int alu(input int op2, input int a, input int b);
    case (op2)
      2: return (a + b) & DMSK;
      3: return (a - b) & DMSK;
      default: return (a * b) & DMSK;
    endcase
  endfunction

  int ra, rb, rop;

  initial begin
    foreach (ref_mem[i]) ref_mem[i] = 0;
    rst = 1'b0; start = 1'b0; clear = 1'b0;
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = AW'(60); hif.host_wdata = DW'(1);

    // Reset state, with a pending host write that must not be granted.
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_cpu_rst", int'(cpu_rst), 1);
    check("rst_timeout", int'(timeout), 0);
    check("rst_cycles", int'(cycles), 0);
    check("rst_rvalid", int'(hif.host_rvalid), 0);
    check("rst_gnt", int'(hif.host_gnt), 0);
    check("rst_ram_we", int'(ram_we), 0);
    hif.host_req = 1'b0; hif.host_we = 1'b0;
    @(negedge clk); rst = 1'b1;

    // Add program: 5 + 10 -> addr 52; clear in LOAD is ignored.
    load_prog(2, 5, 10);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0; #1;
    check("clear_in_load_busy", int'(busy), 0);
    check("clear_in_load_done", int'(done), 0);
    pulse_start(1'b0);
    wait_done();
    ref_mem[52] = 15;
    host_op(1'b0, 52, 0);

    // Rerun straight from DONE with MUL: 5 * 10.
    host_op(1'b1, 1, enc(4, 51));
    pulse_start(1'b0);
    wait_done();
    ref_mem[52] = 50;
    host_op(1'b0, 52, 0);

    // Randomized operands and operations.
    for (int it = 0; it < 5; it++) begin
      if (it % 2 == 1) pulse_clear();
      ra = $urandom_range(0, DMSK); rb = $urandom_range(0, DMSK);
      rop = 2 + $urandom_range(0, 2);
      load_prog(rop, ra, rb);
      pulse_start(1'b0);
      wait_done();
      ref_mem[52] = alu(rop, ra, rb);
      host_op(1'b0, 52, 0);
      host_burst(50, 3);
    end

    // Start in the same cycle as a granted host write (addr 51 = 7).
    pulse_clear();
    load_prog(2, 5, 0);
    exp_run.push_back(1'b0);
    @(negedge clk);
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = AW'(51); hif.host_wdata = DW'(7);
    start = 1'b1;
    #1;
    check("gnt_with_start", int'(hif.host_gnt), 1);
    if (hif.host_gnt) ref_mem[51] = 7;
    @(negedge clk);
    start = 1'b0; hif.host_req = 1'b0; hif.host_we = 1'b0;
    #1;
    check("run_after_start", int'(busy), 1);
    wait_done();
    ref_mem[52] = 12;
    host_op(1'b0, 52, 0);

    // start and clear together in DONE: start wins.
    exp_run.push_back(1'b0);
    @(negedge clk); start = 1'b1; clear = 1'b1;
    @(negedge clk); start = 1'b0; clear = 1'b0;
    #1;
    check("start_beats_clear", int'(busy), 1);
    wait_done();

    // Host read held from RUN entry waits until the first DONE cycle.
    pulse_start(1'b0);
    host_op(1'b0, 50, 0);
    check("arb_gnt_after_run", int'(last_gnt_after_run), 1);
    check("arb_gnt_in_done", int'(last_gnt_done), 1);
    wait_done();

    // Watchdog: JMP 0 loop; start/clear during RUN are ignored.
    host_op(1'b1, 0, enc(6, 0));
    pulse_start(1'b1);
    repeat (8) @(negedge clk);
    start = 1'b1; clear = 1'b1;
    @(negedge clk); start = 1'b0; clear = 1'b0;
    wait_done();
    check("wd_run_length", last_runclks, MAXC);
    check("wd_cycles", int'(cycles), MAXC - 1);
    check("wd_timeout", int'(timeout), 1);
    check("wd_cpu_rst", int'(cpu_rst), 1);

    // Asynchronous reset mid-run with a host write request pending.
    pulse_start(1'b1);
    repeat (10) @(negedge clk);
    hif.host_req = 1'b1; hif.host_we = 1'b1; hif.host_addr = AW'(50); hif.host_wdata = DW'(99);
    #4; rst = 1'b0; #1;
    check("arst_busy", int'(busy), 0);
    check("arst_cpu_rst", int'(cpu_rst), 1);
    check("arst_ram_we", int'(ram_we), 0);
    check("arst_gnt", int'(hif.host_gnt), 0);
    check("arst_done", int'(done), 0);
    exp_run.delete();
    hif.host_req = 1'b0; hif.host_we = 1'b0;
    @(negedge clk); rst = 1'b1; #1;
    check("after_rst_idle", int'(busy | done), 0);
    host_op(1'b0, 50, 0);
    host_burst(50, 3);

    repeat (4) @(negedge clk);
    #3;
    check("scoreboard_drained", exp_rd.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
